// File: rtl/draw_pkg.sv
// Shared constants and types for the framebuffer draw arbiter.
// Screen geometry, pixel widths, requester slot indices and FSM encoding.
package draw_pkg;

    localparam int SCR_W = 160;
    localparam int SCR_H = 120;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;

    localparam int REQ_MENU   = 0;
    localparam int REQ_SPRITE = 1;
    localparam int REQ_ATTACK = 2;
    localparam int REQ_WIN    = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// searching upward and wrapping from N_REQ-1 back to 0.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic             found_o,
    output logic [PW-1:0]    idx_o
);

    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        cand    = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            sum = {1'b0, ptr_i} + (PW+1)'(off);
            if (sum >= (PW+1)'(N_REQ)) begin
                sum = sum - (PW+1)'(N_REQ);
            end
            cand = sum[PW-1:0];
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin owner of the VGA framebuffer write port; a grant is held until
// the owner finishes, abandons, or the watchdog forces it off.
module draw_arbiter #(
    parameter int N_REQ    = 4,
    parameter int X_W      = draw_pkg::X_W,
    parameter int Y_W      = draw_pkg::Y_W,
    parameter int COL_W    = draw_pkg::COL_W,
    parameter int MAX_HOLD = 19200
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       done,
    input  logic [N_REQ-1:0]       plot_in,
    input  logic [N_REQ*X_W-1:0]   x_in,
    input  logic [N_REQ*Y_W-1:0]   y_in,
    input  logic [N_REQ*COL_W-1:0] col_in,
    output logic [N_REQ-1:0]       grant,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [COL_W-1:0]       vga_colour,
    output logic                   vga_plot,
    output logic                   busy,
    output logic [2:0]             owner,
    output logic                   timeout
);

    import draw_pkg::*;

    localparam int PW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_e        state_q;
    logic [N_REQ-1:0]  grant_q;
    logic [PW-1:0]     rrPtr_q;
    logic [PW-1:0]     ownIdx_q;
    logic [HW-1:0]     hold_q;
    logic [HW-1:0]     hold_d;
    logic [X_W-1:0]    vgaX_q;
    logic [Y_W-1:0]    vgaY_q;
    logic [COL_W-1:0]  vgaCol_q;
    logic              vgaPlot_q;
    logic              timeout_q;

    logic              pickFound;
    logic [PW-1:0]     pickIdx;
    logic              ownDone;
    logic              ownReq;
    logic              ownPlot;
    logic [X_W-1:0]    ownX;
    logic [Y_W-1:0]    ownY;
    logic [COL_W-1:0]  ownCol;
    logic [PW-1:0]     nextPtr;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (rrPtr_q),
        .found_o (pickFound),
        .idx_o   (pickIdx)
    );

    // Owner's view of the engine buses; the counter saturates rather than wraps.
    always_comb begin
        ownDone = done[ownIdx_q];
        ownReq  = req[ownIdx_q];
        ownPlot = plot_in[ownIdx_q];
        ownX    = x_in[ownIdx_q*X_W +: X_W];
        ownY    = y_in[ownIdx_q*Y_W +: Y_W];
        ownCol  = col_in[ownIdx_q*COL_W +: COL_W];
        hold_d  = (hold_q == '1) ? hold_q : hold_q + 1'b1;
        nextPtr = (ownIdx_q == PW'(N_REQ - 1)) ? '0 : ownIdx_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rrPtr_q   <= '0;
            ownIdx_q  <= '0;
            hold_q    <= '0;
            vgaX_q    <= '0;
            vgaY_q    <= '0;
            vgaCol_q  <= '0;
            vgaPlot_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    vgaPlot_q <= 1'b0;
                    if (pickFound) begin
                        ownIdx_q <= pickIdx;
                        grant_q  <= N_REQ'(1) << pickIdx;
                        hold_q   <= '0;
                        state_q  <= HOLD;
                    end
                end
                HOLD: begin
                    // The release-edge pixel is still forwarded so it is not lost.
                    vgaX_q    <= ownX;
                    vgaY_q    <= ownY;
                    vgaCol_q  <= ownCol;
                    vgaPlot_q <= ownPlot;
                    hold_q    <= hold_d;
                    if (ownDone || !ownReq || hold_q == HOLD_LAST) begin
                        grant_q   <= '0;
                        rrPtr_q   <= nextPtr;
                        timeout_q <= ownReq && !ownDone;
                        state_q   <= RELEASE;
                    end
                end
                RELEASE: begin
                    vgaPlot_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant      = grant_q;
    assign vga_x      = vgaX_q;
    assign vga_y      = vgaY_q;
    assign vga_colour = vgaCol_q;
    assign vga_plot   = vgaPlot_q;
    assign busy       = (state_q != IDLE);
    assign owner      = 3'(ownIdx_q);
    assign timeout    = timeout_q;

endmodule
